// File: rtl/mega_ram_dp_if.sv
// Single RAM access port: write strobe, byte enables, address, write data
// and registered read data. One instance per RAM port.
interface mega_ram_dp_if #(
    parameter int ADDR_BUS_WIDTH = 12,
    parameter int DATA_BUS_WIDTH = 8
);
    localparam int BE = DATA_BUS_WIDTH / 8;

    logic                      we;
    logic [BE-1:0]             be;
    logic [ADDR_BUS_WIDTH-1:0] addr;
    logic [DATA_BUS_WIDTH-1:0] din;
    logic [DATA_BUS_WIDTH-1:0] dout;

    modport master (output we, be, addr, din, input dout);
    modport slave  (input we, be, addr, din, output dout);
endinterface

// File: rtl/mega_ram_dp.sv
// Dual-port byte-lane-writable synchronous RAM with a full-depth clear engine.
// Port A has priority on same-address, same-lane write collisions. The array
// is split into one byte-wide memory per lane so byte enables map directly
// onto independent write enables.
module mega_ram_dp #(
    parameter int                        ADDR_BUS_WIDTH = 12,
    parameter int                        DATA_BUS_WIDTH = 8,
    parameter string                     RAM_PATH       = "",
    parameter bit                        CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_BUS_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter bit                        WRITE_FIRST    = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_req,
    output logic            clear_busy,
    mega_ram_dp_if.slave    a,
    mega_ram_dp_if.slave    b
);
    localparam int BE    = DATA_BUS_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_BUS_WIDTH;
    localparam logic [ADDR_BUS_WIDTH-1:0] LAST_ADDR = {ADDR_BUS_WIDTH{1'b1}};

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                    state_reg;
    logic [ADDR_BUS_WIDTH-1:0] cnt_reg;
    logic                      clear_busy_reg;

    // Clear engine: walks every address exactly once, then returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            if (CLEAR_ON_RESET) begin
                state_reg      <= CLEAR;
                clear_busy_reg <= 1'b1;
            end else begin
                state_reg      <= IDLE;
                clear_busy_reg <= 1'b0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (clear_req) begin
                        state_reg      <= CLEAR;
                        cnt_reg        <= '0;
                        clear_busy_reg <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_ADDR) begin
                        state_reg      <= IDLE;
                        clear_busy_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    clear_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign clear_busy = clear_busy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BE; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] a_dout_reg;
            logic [7:0] b_dout_reg;
            logic       a_lane_we;
            logic       b_lane_we;

            assign a_lane_we = a.we & a.be[gi];
            assign b_lane_we = b.we & b.be[gi];

            // Lane write: clear engine owns the array while busy; otherwise
            // port B is applied first so port A's write overrides it.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    if (clear_busy_reg) begin
                        mem[cnt_reg] <= CLEAR_VALUE[8*gi +: 8];
                    end else begin
                        if (b_lane_we) mem[b.addr] <= b.din[8*gi +: 8];
                        if (a_lane_we) mem[a.addr] <= a.din[8*gi +: 8];
                    end
                end
            end

            // Lane read: registered, zeroed during reset and clear; the
            // write-first variant forwards this port's own write data.
            always_ff @(posedge clk) begin
                if (rst || clear_busy_reg) begin
                    a_dout_reg <= '0;
                    b_dout_reg <= '0;
                end else begin
                    if (WRITE_FIRST && a_lane_we) a_dout_reg <= a.din[8*gi +: 8];
                    else                          a_dout_reg <= mem[a.addr];
                    if (WRITE_FIRST && b_lane_we) b_dout_reg <= b.din[8*gi +: 8];
                    else                          b_dout_reg <= mem[b.addr];
                end
            end

            assign a.dout[8*gi +: 8] = a_dout_reg;
            assign b.dout[8*gi +: 8] = b_dout_reg;
        end
    endgenerate
endmodule

// File: tb/tb_mega_ram_dp.sv
// Directed bench for mega_ram_dp: two instances (read-first with reset clear,
// write-first without reset clear), expected read data queued per port.
module tb_mega_ram_dp;
    localparam int AW  = 10;
    localparam int AW2 = 4;
    localparam int DW  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clear_req, clear_busy;
    logic rst2, clear_req2, clear_busy2;

    mega_ram_dp_if #(.ADDR_BUS_WIDTH(AW),  .DATA_BUS_WIDTH(DW)) ia ();
    mega_ram_dp_if #(.ADDR_BUS_WIDTH(AW),  .DATA_BUS_WIDTH(DW)) ib ();
    mega_ram_dp_if #(.ADDR_BUS_WIDTH(AW2), .DATA_BUS_WIDTH(DW)) ja ();
    mega_ram_dp_if #(.ADDR_BUS_WIDTH(AW2), .DATA_BUS_WIDTH(DW)) jb ();

    mega_ram_dp #(.ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW), .RAM_PATH(""),
                  .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'h0000_0000), .WRITE_FIRST(1'b0))
        dut (.clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(clear_busy),
             .a(ia), .b(ib));

    mega_ram_dp #(.ADDR_BUS_WIDTH(AW2), .DATA_BUS_WIDTH(DW), .RAM_PATH(""),
                  .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(32'hC3C3_C3C3), .WRITE_FIRST(1'b1))
        dut2 (.clk(clk), .rst(rst2), .clear_req(clear_req2), .clear_busy(clear_busy2),
              .a(ja), .b(jb));

    logic [31:0] model1 [1 << AW];
    logic [31:0] model2 [1 << AW2];
    logic [31:0] q_a [$];
    logic [31:0] q_b [$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = din[8*i +: 8];
        return r;
    endfunction

    // Count consecutive samples with busy high, starting from the current one.
    task automatic count_busy(input bit second, output int c);
        c = 0;
        for (int k = 0; k < 5000; k++) begin
            if (!(second ? clear_busy2 : clear_busy)) break;
            c++;
            tick();
        end
    endtask

    // One cycle on the read-first instance; expected reads are old contents.
    task automatic op1(input string tag,
                       input bit awe, input logic [3:0] abe, input logic [AW-1:0] aaddr,
                       input logic [31:0] adin,
                       input bit bwe, input logic [3:0] bbe, input logic [AW-1:0] baddr,
                       input logic [31:0] bdin);
        ia.we = awe; ia.be = abe; ia.addr = aaddr; ia.din = adin;
        ib.we = bwe; ib.be = bbe; ib.addr = baddr; ib.din = bdin;
        q_a.push_back(model1[aaddr]);
        q_b.push_back(model1[baddr]);
        if (bwe) model1[baddr] = merge(model1[baddr], bdin, bbe);
        if (awe) model1[aaddr] = merge(model1[aaddr], adin, abe);
        tick();
        ia.we = 1'b0; ib.we = 1'b0;
        check({tag, "_a"}, ia.dout, q_a.pop_front());
        check({tag, "_b"}, ib.dout, q_b.pop_front());
    endtask

    // One cycle on the write-first instance; a port's own write is forwarded.
    task automatic op2(input string tag,
                       input bit awe, input logic [3:0] abe, input logic [AW2-1:0] aaddr,
                       input logic [31:0] adin,
                       input bit bwe, input logic [3:0] bbe, input logic [AW2-1:0] baddr,
                       input logic [31:0] bdin);
        ja.we = awe; ja.be = abe; ja.addr = aaddr; ja.din = adin;
        jb.we = bwe; jb.be = bbe; jb.addr = baddr; jb.din = bdin;
        q_a.push_back(awe ? merge(model2[aaddr], adin, abe) : model2[aaddr]);
        q_b.push_back(bwe ? merge(model2[baddr], bdin, bbe) : model2[baddr]);
        if (bwe) model2[baddr] = merge(model2[baddr], bdin, bbe);
        if (awe) model2[aaddr] = merge(model2[aaddr], adin, abe);
        tick();
        ja.we = 1'b0; jb.we = 1'b0;
        check({tag, "_a"}, ja.dout, q_a.pop_front());
        check({tag, "_b"}, jb.dout, q_b.pop_front());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b1; clear_req = 1'b0; rst2 = 1'b1; clear_req2 = 1'b0;
        ia.we = 0; ia.be = '0; ia.addr = '0; ia.din = '0;
        ib.we = 0; ib.be = '0; ib.addr = '0; ib.din = '0;
        ja.we = 0; ja.be = '0; ja.addr = '0; ja.din = '0;
        jb.we = 0; jb.be = '0; jb.addr = '0; jb.din = '0;

        // Reset state of both instances.
        tick();
        check("rst_busy", {31'b0, clear_busy}, 32'd1);
        check("rst_a_dout", ia.dout, 32'h0);
        check("rst_b_dout", ib.dout, 32'h0);
        check("rst2_busy", {31'b0, clear_busy2}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        count_busy(1'b0, c);
        check("init_clear_len", c, 32'd1024);
        for (int i = 0; i < (1 << AW); i++) model1[i] = 32'h0;

        // Preload 0xA5 everywhere, then reset clear must wipe it all.
        for (int i = 0; i < (1 << AW) / 2; i++)
            op1("preload", 1, 4'hF, AW'(2*i), 32'hA5A5_A5A5, 1, 4'hF, AW'(2*i+1), 32'hA5A5_A5A5);
        ia.addr = 10'd5; ib.addr = 10'h3FF;
        rst = 1'b1;
        tick();
        check("rst_dout_zero_a", ia.dout, 32'h0);
        check("rst_dout_zero_b", ib.dout, 32'h0);
        tick(); tick();
        rst = 1'b0;
        count_busy(1'b0, c);
        check("reset_clear_len", c, 32'd1024);
        for (int i = 0; i < (1 << AW); i++) model1[i] = 32'h0;
        for (int i = 0; i < (1 << AW); i++)
            op1("sweep", 0, 4'h0, AW'(i), 32'h0, 0, 4'h0, AW'(1023 - i), 32'h0);

        // Byte enables.
        op1("be_full", 1, 4'hF, 10'd5, 32'h1122_3344, 0, 4'h0, 10'd0, 32'h0);
        op1("be_part", 1, 4'b0101, 10'd5, 32'hAABB_CCDD, 0, 4'h0, 10'd0, 32'h0);
        op1("be_read", 0, 4'h0, 10'd5, 32'h0, 0, 4'h0, 10'd5, 32'h0);
        check("be_lit", ia.dout, 32'h11BB_33DD);

        // Same-address collision: A wins its lanes, B keeps the rest.
        op1("coll", 1, 4'b1100, 10'd7, 32'hFFFF_0000, 1, 4'b1111, 10'd7, 32'h1234_5678);
        op1("coll_rd", 0, 4'h0, 10'd7, 32'h0, 0, 4'h0, 10'd7, 32'h0);
        check("coll_lit", ib.dout, 32'hFFFF_5678);

        // Read-during-write, read-first instance.
        op1("rdw_init", 1, 4'hF, 10'd3, 32'h40, 0, 4'h0, 10'd0, 32'h0);
        op1("rdw", 1, 4'hF, 10'd3, 32'h41, 0, 4'h0, 10'd3, 32'h0);
        check("rdw_a_old", ia.dout, 32'h40);
        check("rdw_b_old", ib.dout, 32'h40);
        op1("rdw_after", 0, 4'h0, 10'd3, 32'h0, 0, 4'h0, 10'd3, 32'h0);

        // Runtime clear: writes dropped, dout zero, repeated request ignored.
        op1("pre_rt", 1, 4'hF, 10'd9, 32'h99, 0, 4'h0, 10'd0, 32'h0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("rt_busy_rise", {31'b0, clear_busy}, 32'd1);
        c = 1;
        for (int k = 0; k < 5000; k++) begin
            clear_req = (c == 500);
            ia.we = (c == 10); ia.be = 4'hF; ia.addr = 10'd0; ia.din = 32'hDEAD_BEEF;
            ib.we = 1'b0; ib.addr = 10'd9;
            tick();
            if (c == 10) check("busy_dout_b", ib.dout, 32'h0);
            if (!clear_busy) break;
            c++;
        end
        clear_req = 1'b0; ia.we = 1'b0;
        check("rt_clear_len", c, 32'd1024);
        for (int i = 0; i < (1 << AW); i++) model1[i] = 32'h0;
        op1("post_rt", 0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd9, 32'h0);
        op1("first_wr", 1, 4'hF, 10'd1, 32'h0BAD_CAFE, 0, 4'h0, 10'd0, 32'h0);
        op1("first_rd", 0, 4'h0, 10'd1, 32'h0, 0, 4'h0, 10'd1, 32'h0);

        // Runtime clear interrupted by reset at cycle 100.
        for (int i = 0; i <= 100; i++) begin
            clear_req = (i == 0);
            rst = (i == 100);
            ia.we = (i == 50); ia.be = 4'hF; ia.addr = 10'd0; ia.din = 32'hCAFE_F00D;
            tick();
            if (i == 50) check("int_busy", {31'b0, clear_busy}, 32'd1);
        end
        rst = 1'b0; clear_req = 1'b0; ia.we = 1'b0;
        count_busy(1'b0, c);
        check("int_clear_len", c, 32'd1024);
        for (int i = 0; i < (1 << AW); i++) model1[i] = 32'h0;
        op1("int_rd", 0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd1, 32'h0);

        // Second instance: no reset clear, write-first.
        ja.addr = 4'd2;
        tick();
        check("r2_dout", ja.dout, 32'h0);
        rst2 = 1'b0;
        for (int i = 0; i < (1 << AW2) / 2; i++)
            op2("load2", 1, 4'hF, AW2'(2*i), 32'h5A5A_5A5A, 1, 4'hF, AW2'(2*i+1), 32'h5A5A_5A5A);
        ja.addr = 4'd4; jb.addr = 4'd11;
        rst2 = 1'b1;
        tick();
        check("r2_busy_rst", {31'b0, clear_busy2}, 32'd0);
        check("r2_dout_rst", ja.dout, 32'h0);
        tick();
        rst2 = 1'b0;
        tick();
        check("r2_busy_after", {31'b0, clear_busy2}, 32'd0);
        for (int i = 0; i < (1 << AW2); i++)
            op2("keep2", 0, 4'h0, AW2'(i), 32'h0, 0, 4'h0, AW2'(15 - i), 32'h0);
        check("keep2_lit", ja.dout, 32'h5A5A_5A5A);

        op2("rdw2_init", 1, 4'hF, 4'd3, 32'h40, 0, 4'h0, 4'd0, 32'h0);
        op2("rdw2", 1, 4'hF, 4'd3, 32'h41, 0, 4'h0, 4'd3, 32'h0);
        check("rdw2_a_new", ja.dout, 32'h41);
        check("rdw2_b_old", jb.dout, 32'h40);
        op2("mrg_init", 1, 4'hF, 4'd4, 32'h1122_3344, 0, 4'h0, 4'd0, 32'h0);
        op2("mrg", 1, 4'b0110, 4'd4, 32'hAABB_CCDD, 0, 4'h0, 4'd4, 32'h0);
        check("mrg_a_lit", ja.dout, 32'h11BB_CC44);
        check("mrg_b_old", jb.dout, 32'h1122_3344);

        clear_req2 = 1'b1;
        tick();
        clear_req2 = 1'b0;
        count_busy(1'b1, c);
        check("r2_clear_len", c, 32'd16);
        for (int i = 0; i < (1 << AW2); i++) model2[i] = 32'hC3C3_C3C3;
        op2("r2_cleared", 0, 4'h0, 4'd4, 32'h0, 0, 4'h0, 4'd15, 32'h0);
        check("r2_clear_lit", ja.dout, 32'hC3C3_C3C3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
